// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM front-end.
package ram_arb_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 2;
   localparam int unsigned DATA_WIDTH_DEF = 4;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is chosen.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  req_id_t    last_gnt,
   output logic [1:0] gnt,
   output req_id_t    gnt_id
);

   always_comb begin
      gnt    = '0;
      gnt_id = 1'b0;
      case (valid)
         2'b01: begin
            gnt    = 2'b01;
            gnt_id = 1'b0;
         end
         2'b10: begin
            gnt    = 2'b10;
            gnt_id = 1'b1;
         end
         2'b11: begin
            gnt_id = ~last_gnt;
            gnt    = last_gnt ? 2'b01 : 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ram4x4_arbiter.sv
// Round-robin front-end sharing one single-port RAM between two clients,
// with a post-reset hold-off and per-requester routing of read data.
module ram4x4_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned INIT_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              req_ready,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    mem_sel,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_din,
   input  logic [DATA_WIDTH-1:0]   mem_dout,
   output logic                    init_done
);

   localparam int unsigned CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   req_id_t                 last_gnt_q, last_gnt_d;
   logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
   logic [DATA_WIDTH-1:0]   din_hold_q, din_hold_d;
   logic                    rsp_pend_q, rsp_pend_d;
   req_id_t                 rsp_id_q, rsp_id_d;

   logic                    run;
   logic [1:0]              arb_valid;
   logic [1:0]              gnt;
   req_id_t                 gnt_id;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   // Reset is synchronous, so outputs are also masked while it is asserted
   // to keep the RAM pins and response quiet during the reset cycle itself.
   assign run       = (state_q == ST_RUN) && !reset;
   assign arb_valid = run ? req_valid : 2'b00;
   assign sel_addr  = gnt_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
   assign sel_wdata = gnt_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

   rr_arb2 u_arb (
      .valid    (arb_valid),
      .last_gnt (last_gnt_q),
      .gnt      (gnt),
      .gnt_id   (gnt_id)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_gnt_d  = last_gnt_q;
      addr_hold_d = addr_hold_q;
      din_hold_d  = din_hold_q;
      rsp_pend_d  = 1'b0;
      rsp_id_d    = rsp_id_q;
      req_ready   = '0;
      mem_sel     = 1'b0;
      mem_addr    = '0;
      mem_din     = '0;

      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (run) begin
               mem_addr = addr_hold_q;
               mem_din  = din_hold_q;
            end
            if (|gnt) begin
               req_ready   = gnt;
               mem_sel     = req_we[gnt_id];
               mem_addr    = sel_addr;
               mem_din     = sel_wdata;
               last_gnt_d  = gnt_id;
               addr_hold_d = sel_addr;
               din_hold_d  = sel_wdata;
               rsp_pend_d  = ~req_we[gnt_id];
               rsp_id_d    = gnt_id;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         last_gnt_q  <= 1'b1;
         addr_hold_q <= '0;
         din_hold_q  <= '0;
         rsp_pend_q  <= 1'b0;
         rsp_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_gnt_q  <= last_gnt_d;
         addr_hold_q <= addr_hold_d;
         din_hold_q  <= din_hold_d;
         rsp_pend_q  <= rsp_pend_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign rsp_valid = (rsp_pend_q && !reset) ? (rsp_id_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata = (|rsp_valid) ? mem_dout : '0;
   assign init_done = (state_q == ST_RUN) && !reset;

endmodule

// File: tb/tb_ram4x4_arbiter.sv
// Directed bench for ram4x4_arbiter with a behavioural 4x4 RAM attached to its pins.
module tb_ram4x4_arbiter;

   localparam int unsigned AW = 2;
   localparam int unsigned DW = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_we = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic [1:0]      req_ready;
   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            mem_sel;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_din;
   logic [DW-1:0]   mem_dout;
   logic            init_done;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   // RAM: write on SEL=1, registered read on SEL=0
   logic [DW-1:0] ram [4];
   always @(posedge clk) begin
      if (mem_sel) ram[mem_addr] <= mem_din;
      else         mem_dout      <= ram[mem_addr];
   end

   ram4x4_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_sel   (mem_sel),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .init_done (init_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 2'b00;
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         total_cnt++;
         if ({req_ready, rsp_valid, rsp_rdata, mem_sel, mem_addr, mem_din, init_done} !== '0)
            $display("FAIL reset_outputs cycle %0d: got ready=%b rsp=%b rdata=%h sel=%b addr=%h din=%h done=%b, need all 0",
                     c, req_ready, rsp_valid, rsp_rdata, mem_sel, mem_addr, mem_din, init_done);
         else pass_cnt++;
      end
   endtask

   task automatic test_holdoff();
      tick();
      reset = 1'b0;
      req_valid = 2'b01; req_we = 2'b01;
      req_addr = {2'd0, 2'd0}; req_wdata = {4'h0, 4'h5};
      for (int c = 0; c < 5; c++) begin
         #1;
         total_cnt++;
         if (req_ready !== ((c == 4) ? 2'b01 : 2'b00) || init_done !== (c == 4))
            $display("FAIL holdoff cycle %0d: got ready=%b done=%b, need ready=%b done=%b",
                     c, req_ready, init_done, (c == 4) ? 2'b01 : 2'b00, (c == 4));
         else pass_cnt++;
         if (c == 4) begin
            total_cnt++;
            if ({mem_sel, mem_addr, mem_din} !== {1'b1, 2'd0, 4'h5})
               $display("FAIL holdoff_first_write: got sel=%b addr=%h din=%h, need 1/0/5", mem_sel, mem_addr, mem_din);
            else pass_cnt++;
         end
         tick();
      end
      req_addr = {2'd0, 2'd3}; req_wdata = {4'h0, 4'hC};
      #1;
      total_cnt++;
      if (req_ready !== 2'b01 || mem_addr !== 2'd3)
         $display("FAIL preload_c: got ready=%b addr=%h, need 01/3", req_ready, mem_addr);
      else pass_cnt++;
      tick();
      req_valid = 2'b00;
   endtask

   task automatic test_write_read();
      req_valid = 2'b01; req_we = 2'b01;
      req_addr = {2'd0, 2'd2}; req_wdata = {4'h0, 4'hA};
      #1;
      total_cnt++;
      if (req_ready !== 2'b01 || mem_sel !== 1'b1)
         $display("FAIL wr_accept: got ready=%b sel=%b, need 01/1", req_ready, mem_sel);
      else pass_cnt++;
      tick();
      req_valid = 2'b10; req_we = 2'b00; req_addr = {2'd2, 2'd0};
      #1;
      total_cnt++;
      if (req_ready !== 2'b10 || mem_sel !== 1'b0 || mem_addr !== 2'd2 || rsp_valid !== 2'b00)
         $display("FAIL rd_accept: got ready=%b sel=%b addr=%h rsp=%b, need 10/0/2/00",
                  req_ready, mem_sel, mem_addr, rsp_valid);
      else pass_cnt++;
      tick();
      req_valid = 2'b00;
      #1;
      total_cnt++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== 4'hA)
         $display("FAIL wr_rd_rsp: got rsp=%b rdata=%h, need 10/a", rsp_valid, rsp_rdata);
      else pass_cnt++;
      tick();
      #1;
      total_cnt++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== 4'h0)
         $display("FAIL wr_rd_rsp_end: got rsp=%b rdata=%h, need 00/0", rsp_valid, rsp_rdata);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      logic [1:0] prev_g;
      prev_g = 2'b00;
      req_valid = 2'b11; req_we = 2'b00; req_addr = {2'd3, 2'd0};
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         total_cnt++;
         if (req_ready !== exp_g)
            $display("FAIL contention_grant %0d: got %b, need %b", k, req_ready, exp_g);
         else pass_cnt++;
         if (k > 0) begin
            total_cnt++;
            if (rsp_valid !== prev_g || rsp_rdata !== ((prev_g == 2'b01) ? 4'h5 : 4'hC))
               $display("FAIL contention_rsp %0d: got rsp=%b rdata=%h, need %b/%h",
                        k, rsp_valid, rsp_rdata, prev_g, (prev_g == 2'b01) ? 4'h5 : 4'hC);
            else pass_cnt++;
         end
         prev_g = exp_g;
         tick();
      end
      req_valid = 2'b00;
      #1;
      total_cnt++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== 4'hC)
         $display("FAIL contention_last_rsp: got rsp=%b rdata=%h, need 10/c", rsp_valid, rsp_rdata);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_streaming();
      req_valid = 2'b10;
      for (int j = 0; j < 8; j++) begin
         req_we = (j < 4) ? 2'b10 : 2'b00;
         req_addr = {AW'(j % 4), 2'd1};
         req_wdata = {DW'(j + 1), 4'hF};
         #1;
         total_cnt++;
         if (req_ready !== 2'b10 || mem_sel !== (j < 4) || mem_addr !== AW'(j % 4))
            $display("FAIL stream_accept %0d: got ready=%b sel=%b addr=%h, need 10/%b/%h",
                     j, req_ready, mem_sel, mem_addr, (j < 4), AW'(j % 4));
         else pass_cnt++;
         total_cnt++;
         if (j >= 5) begin
            if (rsp_valid !== 2'b10 || rsp_rdata !== DW'(j - 4))
               $display("FAIL stream_rsp %0d: got rsp=%b rdata=%h, need 10/%h", j, rsp_valid, rsp_rdata, DW'(j - 4));
            else pass_cnt++;
         end else begin
            if (rsp_valid !== 2'b00)
               $display("FAIL stream_no_rsp %0d: got rsp=%b, need 00", j, rsp_valid);
            else pass_cnt++;
         end
         tick();
      end
      req_valid = 2'b00;
      #1;
      total_cnt++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== 4'h4)
         $display("FAIL stream_last_rsp: got rsp=%b rdata=%h, need 10/4", rsp_valid, rsp_rdata);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_idle();
      req_valid = 2'b00;
      for (int c = 0; c < 10; c++) begin
         #1;
         total_cnt++;
         if ({req_ready, mem_sel, rsp_valid, rsp_rdata} !== '0 || mem_addr !== 2'd3 || mem_din !== 4'h8)
            $display("FAIL idle %0d: got ready=%b sel=%b rsp=%b rdata=%h addr=%h din=%h, need 0/0/0/0/3/8",
                     c, req_ready, mem_sel, rsp_valid, rsp_rdata, mem_addr, mem_din);
         else pass_cnt++;
         tick();
      end
      req_valid = 2'b01; req_we = 2'b00;
      for (int j = 0; j < 5; j++) begin
         if (j == 4) req_valid = 2'b00;
         req_addr = {2'd0, AW'(j % 4)};
         #1;
         if (j > 0) begin
            total_cnt++;
            if (rsp_valid !== 2'b01 || rsp_rdata !== DW'(j))
               $display("FAIL idle_readback %0d: got rsp=%b rdata=%h, need 01/%h", j - 1, rsp_valid, rsp_rdata, DW'(j));
            else pass_cnt++;
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      req_valid = 2'b01; req_we = 2'b00; req_addr = {2'd0, 2'd1};
      #1;
      total_cnt++;
      if (req_ready !== 2'b01)
         $display("FAIL midrst_accept: got ready=%b, need 01", req_ready);
      else pass_cnt++;
      tick();
      reset = 1'b1;
      #1;
      total_cnt++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== 4'h0 || req_ready !== 2'b00 || init_done !== 1'b0)
         $display("FAIL midrst_cycle: got rsp=%b rdata=%h ready=%b done=%b, need 00/0/00/0",
                  rsp_valid, rsp_rdata, req_ready, init_done);
      else pass_cnt++;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         total_cnt++;
         if (req_ready !== ((c == 4) ? 2'b01 : 2'b00) || rsp_valid !== 2'b00)
            $display("FAIL midrst_holdoff %0d: got ready=%b rsp=%b, need %b/00",
                     c, req_ready, rsp_valid, (c == 4) ? 2'b01 : 2'b00);
         else pass_cnt++;
         tick();
      end
      req_valid = 2'b00;
      #1;
      total_cnt++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 4'h2)
         $display("FAIL midrst_rsp: got rsp=%b rdata=%h, need 01/2", rsp_valid, rsp_rdata);
      else pass_cnt++;
      tick();
   endtask

   initial begin
      test_reset();
      test_holdoff();
      test_write_read();
      test_contention();
      test_streaming();
      test_idle();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ram4x4_arbiter.md
# ram4x4_arbiter

Two-requester round-robin controller that shares one 4-word x 4-bit single-port R/W RAM (write on SEL=1, registered read on SEL=0) between two independent clients. Sits directly in front of the RAM and owns its SEL/Addr/Din pins. Runs a post-reset hold-off so no access reaches the RAM before it is ready. Returns read data to the requester that issued the read.

## Interface
- ADDR_WIDTH, 2, RAM address width
- DATA_WIDTH, 4, RAM data width
- INIT_CYCLES, 4, cycles after reset release during which no grant is issued (RAM settle window); must be ≥1
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  bit i: requester i presents a transaction; held with payload stable until accepted
- req_we  in  2  bit i: 1 = write, 0 = read
- req_addr  in  2×ADDR_WIDTH  packed, slice i = requester i address
- req_wdata  in  2×DATA_WIDTH  packed, slice i = requester i write data
- req_ready  out  2  bit i: requester i accepted this cycle (one-hot or zero)
- rsp_valid  out  2  bit i: read data for requester i valid this cycle (one-hot or zero)
- rsp_rdata  out  DATA_WIDTH  read data, 0 when rsp_valid == 0
- mem_sel  out  1  RAM SEL (1 = write)
- mem_addr  out  ADDR_WIDTH  RAM Addr
- mem_din  out  DATA_WIDTH  RAM Din
- mem_dout  in  DATA_WIDTH  RAM Dout (registered inside RAM, 1-cycle read latency)
- init_done  out  1  high once the hold-off has expired

## Operation
- States: ST_INIT, ST_RUN. Reset → ST_INIT, counter = 0.
- ST_INIT: counter increments each cycle; when counter == INIT_CYCLES-1 → ST_RUN next cycle. req_ready = 0, mem_sel = 0, mem_addr = 0, mem_din = 0.
- ST_RUN: one transaction per cycle. Grant combinational from req_valid and round-robin pointer last_gnt:
  - exactly one valid → grant it;
  - both valid → grant requester != last_gnt;
  - none valid → no grant, mem_sel = 0, mem_addr/mem_din hold last driven values (registered copies).
- On grant i: req_ready[i] = 1; mem_sel = req_we[i]; mem_addr/mem_din = slice i; last_gnt <= i.
- Read accepted in cycle T: rsp_valid[i] = 1 in T+1 only, rsp_rdata = mem_dout in T+1. Tag (valid bit + requester id) registered at T.
- Write produces no response.
- Reset value of last_gnt = 1 (requester 0 wins first tie).
- Fairness: a continuously valid requester waits at most 1 cycle.
- Reset asserted mid-operation: pending response tag cleared (no rsp_valid after reset), state → ST_INIT, counter → 0, hold-off restarts.
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, mem_sel = 0, mem_addr = 0, mem_din = 0, init_done = 0.

## Timing
- Accept-to-response latency for reads: exactly 1 cycle; back-to-back reads sustain 1 response/cycle.
- Write at T visible to a read accepted at T+1 (RAM writes at edge ending T).
- init_done rises in the first ST_RUN cycle, i.e. INIT_CYCLES cycles after the first cycle with reset low.
- req_ready and mem_* are combinational from req_valid/req_* and registered state; no combinational path from mem_dout to req_ready.
- Grant decision and response are independent: a new grant may coincide with rsp_valid for the previous read, same or other requester.

## Structure
- Package ram_arb_pkg: state enum (ST_INIT, ST_RUN), default ADDR_WIDTH/DATA_WIDTH, requester-id type (1 bit).
- Sub-module rr_arb2: inputs valid[1:0], last_gnt; outputs gnt one-hot and gnt_id. Pointer register stays in ram4x4_arbiter.

## Test plan
- Hold-off: reset low, req_valid = 2'b01 from cycle 0 → req_ready stays 0 for 4 cycles, first accept in cycle 4, init_done rises in cycle 4.
- Write then read: req0 write addr 2 data 0xA, next cycle req1 read addr 2 → req1 rsp_valid one cycle after accept with rsp_rdata = 0xA, rsp_valid[0] never set.
- Contention: both requesters read continuously (addr 0 / addr 3, preloaded 0x5 / 0xC) → grants alternate 0,1,0,1 starting with 0; responses alternate with 0x5, 0xC, each 1 cycle after its grant.
- Single requester streaming: req1 alone, 4 writes to addr 0..3 with 0x1..0x4, then 4 reads → one accept per cycle, reads return 0x1..0x4 in order.
- Reset mid-read: read accepted at T, reset high at T+1 → rsp_valid = 0 at T+1 and after; hold-off restarts, no grant until 4 cycles after reset drops.
- Idle: no req_valid for 10 cycles in ST_RUN → mem_sel = 0 throughout, rsp_valid = 0, rsp_rdata = 0, RAM contents unchanged on later readback.
